// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: access sizes, load-select codes
// (also decoded by the load-data mask) and the sequencer state.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_t;

  localparam logic [2:0] LD_SEL_LW  = 3'b000;
  localparam logic [2:0] LD_SEL_LHU = 3'b001;
  localparam logic [2:0] LD_SEL_LH  = 3'b010;
  localparam logic [2:0] LD_SEL_LBU = 3'b011;
  localparam logic [2:0] LD_SEL_LB  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_t;

  function automatic logic [2:0] ld_sel_of(input logic [1:0] size, input logic is_unsigned);
    case (size)
      SIZE_B:  return is_unsigned ? LD_SEL_LBU : LD_SEL_LB;
      SIZE_H:  return is_unsigned ? LD_SEL_LHU : LD_SEL_LH;
      default: return LD_SEL_LW;
    endcase
  endfunction

endpackage

// File: rtl/mem_store_align.sv
// Combinational store lane placement: byte enables, lane-replicated write data
// and the alignment check for a request's size and low address bits.
module mem_store_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [3:0]  wbe,
  output logic [31:0] wdata,
  output logic        aligned
);

  always_comb begin
    wbe     = 4'b0000;
    wdata   = data;
    aligned = 1'b0;
    case (size)
      SIZE_B: begin
        wbe     = 4'b0001 << addr_lo;
        wdata   = {4{data[7:0]}};
        aligned = 1'b1;
      end
      SIZE_H: begin
        wbe     = 4'b0011 << addr_lo;
        wdata   = {2{data[15:0]}};
        aligned = ~addr_lo[0];
      end
      SIZE_W: begin
        wbe     = 4'b1111;
        aligned = (addr_lo == 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: accepts one request per handshake, drives a word-addressed
// memory port and hands raw load words to the load-data mask, with a response timeout.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_is_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wbe,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic [2:0]  ld_select,
  output logic [31:0] ld_addr,
  output logic        st_done,
  output logic        misalign,
  output logic        timeout_err,
  output logic [1:0]  fsm_state
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_store_q;
  logic [31:0]      addr_q;
  logic [2:0]       sel_q;
  logic [3:0]       al_wbe;
  logic [31:0]      al_wdata;
  logic             al_ok;
  logic             timeout_hit;

  assign fsm_state = state;

  // The abort fires on the last allowed cycle so exactly TIMEOUT_CYCLES are spent waiting.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

  mem_store_align u_align (
    .size    (req_size),
    .addr_lo (req_addr[1:0]),
    .data    (req_wdata),
    .wbe     (al_wbe),
    .wdata   (al_wdata),
    .aligned (al_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      req_ready     <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wbe       <= '0;
      is_store_q    <= 1'b0;
      addr_q        <= '0;
      sel_q         <= '0;
      ld_valid      <= 1'b0;
      ld_data       <= '0;
      ld_select     <= '0;
      ld_addr       <= '0;
      st_done       <= 1'b0;
      misalign      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      ld_valid    <= 1'b0;
      st_done     <= 1'b0;
      misalign    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (req_valid) begin
            if (al_ok) begin
              mem_addr      <= {req_addr[31:2], 2'b00};
              mem_wdata     <= al_wdata;
              mem_wbe       <= req_is_store ? al_wbe : 4'b0000;
              is_store_q    <= req_is_store;
              addr_q        <= req_addr;
              sel_q         <= ld_sel_of(req_size, req_unsigned);
              mem_req_valid <= 1'b1;
              req_ready     <= 1'b0;
              state         <= ST_ISSUE;
            end else begin
              misalign <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            cnt           <= '0;
            if (is_store_q) begin
              st_done   <= 1'b1;
              req_ready <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              state <= ST_WAIT;
            end
          end else if (timeout_hit) begin
            mem_req_valid <= 1'b0;
            timeout_err   <= 1'b1;
            req_ready     <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            ld_valid  <= 1'b1;
            ld_data   <= mem_rdata;
            ld_select <= sel_q;
            ld_addr   <= addr_q;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end else if (timeout_hit) begin
            timeout_err <= 1'b1;
            req_ready   <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          mem_req_valid <= 1'b0;
          req_ready     <= 1'b1;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, random transactions against a
// reference model, and hand-written timeout / stall / reset sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_is_store = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        req_ready, mem_req_valid, ld_valid, st_done, misalign, timeout_err;
  logic [31:0] mem_addr, mem_wdata, ld_data, ld_addr;
  logic [3:0]  mem_wbe;
  logic [2:0]  ld_select;
  logic [1:0]  fsm_state;

  logic        t_req_ready, t_mem_req_valid, t_ld_valid, t_st_done, t_misalign, t_timeout_err;
  logic [31:0] t_mem_addr, t_mem_wdata, t_ld_data, t_ld_addr;
  logic [3:0]  t_mem_wbe;
  logic [2:0]  t_ld_select;
  logic [1:0]  t_fsm_state;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_is_store(req_is_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wbe(mem_wbe), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_select(ld_select), .ld_addr(ld_addr),
    .st_done(st_done), .misalign(misalign), .timeout_err(timeout_err), .fsm_state(fsm_state)
  );

  mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut_to (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(t_req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_is_store(req_is_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .mem_req_valid(t_mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_wbe(t_mem_wbe), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .ld_valid(t_ld_valid), .ld_data(t_ld_data), .ld_select(t_ld_select), .ld_addr(t_ld_addr),
    .st_done(t_st_done), .misalign(t_misalign), .timeout_err(t_timeout_err),
    .fsm_state(t_fsm_state)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic        ok;
    logic [3:0]  wbe;
    logic [31:0] mwd;
    logic [2:0]  sel;
    logic [31:0] rdata;
  } vec_t;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [66:0] exp_q[$];
  logic [31:0] last_ld_data = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lane rules expressed as byte counts and multiplications.
  function automatic vec_t model(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic st, input logic [1:0] size, input logic uns,
                                 input logic [31:0] rdata);
    vec_t v;
    int   nbytes;
    v = '0;
    v.addr = addr; v.wdata = wdata; v.st = st; v.size = size; v.uns = uns; v.rdata = rdata;
    nbytes = 1 << size;
    v.ok = (size != 2'd3) && ((addr % nbytes) == 0);
    v.wbe = st ? 4'(((1 << nbytes) - 1) << (addr % 4)) : 4'd0;
    if (size == 2'd0)      v.mwd = 32'(wdata[7:0]) * 32'h0101_0101;
    else if (size == 2'd1) v.mwd = 32'(wdata[15:0]) * 32'h0001_0001;
    else                   v.mwd = wdata;
    if (size == 2'd2)      v.sel = 3'd0;
    else if (size == 2'd1) v.sel = uns ? 3'd1 : 3'd2;
    else                   v.sel = uns ? 3'd3 : 3'd4;
    return v;
  endfunction

  // Drive one request at the current cycle and follow it to completion on dut.
  task automatic run_access(input vec_t v, input int rdy_dly, input int rsp_dly);
    logic [66:0] e;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = v.addr; req_wdata = v.wdata;
    req_is_store = v.st; req_size = v.size; req_unsigned = v.uns;
    step();
    req_valid = 1'b0; req_wdata = $urandom();
    if (!v.ok) begin
      check("misalign_pulse", 32'(misalign), 32'd1);
      check("no_mem_req", 32'(mem_req_valid), 32'd0);
      return;
    end
    check("misalign_clear", 32'(misalign), 32'd0);
    for (int i = 0; i <= rdy_dly; i++) begin
      check("mem_req_valid", 32'(mem_req_valid), 32'd1);
      check("mem_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
      check("mem_wbe", 32'(mem_wbe), 32'(v.wbe));
      if (v.st) check("mem_wdata", mem_wdata, v.mwd);
      if (i == rdy_dly) mem_req_ready = 1'b1;
      step();
    end
    mem_req_ready = 1'b0;
    check("mem_req_drop", 32'(mem_req_valid), 32'd0);
    if (v.st) begin
      check("st_done", 32'(st_done), 32'd1);
      check("ready_after_st", 32'(req_ready), 32'd1);
      check("ld_data_hold", ld_data, last_ld_data);
      return;
    end
    check("no_st_done_ld", 32'(st_done), 32'd0);
    exp_q.push_back({v.sel, v.addr, v.rdata});
    for (int i = 0; i < rsp_dly; i++) begin
      check("ld_valid_early", 32'(ld_valid), 32'd0);
      check("busy_in_wait", 32'(req_ready), 32'd0);
      step();
    end
    mem_resp_valid = 1'b1; mem_rdata = v.rdata;
    step();
    mem_resp_valid = 1'b0; mem_rdata = $urandom();
    check("ld_valid", 32'(ld_valid), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ld_select", 32'(ld_select), 32'(e[66:64]));
      check("ld_addr", ld_addr, e[63:32]);
      check("ld_data", ld_data, e[31:0]);
      last_ld_data = e[31:0];
    end
    check("ready_after_ld", 32'(req_ready), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    last_ld_data = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[11];
  vec_t rv;

  initial begin
    //               addr          wdata         st    sz    uns   ok    wbe      mwd           sel   rdata
    tbl[0]  = '{32'h0000_1003, 32'h0000_00AB, 1'b1, 2'd0, 1'b0, 1'b1, 4'b1000, 32'hABAB_ABAB, 3'd0, 32'h0};
    tbl[1]  = '{32'h0000_2002, 32'h1234_5678, 1'b1, 2'd1, 1'b0, 1'b1, 4'b1100, 32'h5678_5678, 3'd0, 32'h0};
    tbl[2]  = '{32'h0000_3000, 32'hDEAD_BEEF, 1'b1, 2'd2, 1'b0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 3'd0, 32'h0};
    tbl[3]  = '{32'h0000_2002, 32'h0,         1'b0, 2'd1, 1'b0, 1'b1, 4'b0000, 32'h0, 3'b010, 32'h8001_1234};
    tbl[4]  = '{32'h0000_4001, 32'h0,         1'b0, 2'd0, 1'b1, 1'b1, 4'b0000, 32'h0, 3'b011, 32'h1122_3344};
    tbl[5]  = '{32'h0000_3001, 32'h0,         1'b0, 2'd2, 1'b0, 1'b0, 4'b0000, 32'h0, 3'd0, 32'h0};
    tbl[6]  = '{32'h0000_5000, 32'h0,         1'b0, 2'd3, 1'b0, 1'b0, 4'b0000, 32'h0, 3'd0, 32'h0};
    tbl[7]  = '{32'h0000_1001, 32'h0000_BEEF, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000, 32'h0, 3'd0, 32'h0};
    tbl[8]  = '{32'h0000_6000, 32'h0,         1'b0, 2'd1, 1'b1, 1'b1, 4'b0000, 32'h0, 3'b001, 32'hCAFE_F00D};
    tbl[9]  = '{32'h0000_7003, 32'h0,         1'b0, 2'd0, 1'b0, 1'b1, 4'b0000, 32'h0, 3'b100, 32'h0BAD_CAFE};
    tbl[10] = '{32'h0000_8004, 32'h0,         1'b0, 2'd2, 1'b0, 1'b1, 4'b0000, 32'h0, 3'b000, 32'h7654_3210};

    // Reset state while rst is held.
    step();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_ld_valid", 32'(ld_valid), 32'd0);
    check("rst_st_done", 32'(st_done), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_mem_wbe", 32'(mem_wbe), 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    rst = 1'b0;
    step();

    // Directed table, back-to-back with no memory stalls.
    foreach (tbl[i]) run_access(tbl[i], 0, 0);
    step();
    check("pulses_clear_idle", 32'({ld_valid, st_done, misalign, timeout_err}), 32'd0);

    // Request held off for three cycles: outputs stable, one handshake.
    run_access(model(32'h0000_9002, 32'h0000_A5C3, 1'b1, 2'd1, 1'b0, 32'h0), 3, 0);
    step();
    check("single_handshake", 32'(mem_req_valid), 32'd0);
    check("no_second_st_done", 32'(st_done), 32'd0);
    run_access(model(32'h0000_9004, 32'h0, 1'b0, 2'd2, 1'b0, 32'h1357_9BDF), 3, 2);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 60; n++) begin
      rv = model($urandom(), $urandom(), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom());
      run_access(rv, $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) step();
    end

    // Timeout in WAIT on the short-timeout instance, then a stale response.
    do_reset();
    req_valid = 1'b1; req_addr = 32'h40; req_is_store = 1'b0; req_size = 2'd2;
    step();
    req_valid = 1'b0;
    check("to_issue", 32'(t_mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_wait_no_err", 32'(t_timeout_err), 32'd0);
      step();
    end
    check("to_wait_err", 32'(t_timeout_err), 32'd1);
    check("to_wait_ready", 32'(t_req_ready), 32'd1);
    check("to_wait_no_ld", 32'(t_ld_valid), 32'd0);
    mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_0000;
    step();
    mem_resp_valid = 1'b0;
    check("to_err_once", 32'(t_timeout_err), 32'd0);
    check("stale_resp_ignored", 32'(t_ld_valid), 32'd0);
    check("stale_ld_data", t_ld_data, 32'd0);

    // Timeout in ISSUE: memory never accepts.
    do_reset();
    req_valid = 1'b1; req_addr = 32'h80; req_is_store = 1'b1; req_size = 2'd2;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_issue_hold", 32'(t_mem_req_valid), 32'd1);
      step();
    end
    check("to_issue_err", 32'(t_timeout_err), 32'd1);
    check("to_issue_drop", 32'(t_mem_req_valid), 32'd0);
    check("to_issue_no_st", 32'(t_st_done), 32'd0);

    // Asynchronous reset while waiting for load data.
    do_reset();
    req_valid = 1'b1; req_addr = 32'hC0; req_is_store = 1'b0; req_size = 2'd2;
    step();
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("wait_before_rst", 32'(req_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ready", 32'(req_ready), 32'd1);
    check("async_rst_state", 32'(fsm_state), 32'd0);
    check("async_rst_memv", 32'(mem_req_valid), 32'd0);
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 32'h1234_ABCD;
    step();
    mem_resp_valid = 1'b0;
    check("post_rst_no_ld", 32'(ld_valid), 32'd0);
    step();
    check("post_rst_ld_data", ld_data, 32'd0);
    check("post_rst_idle", 32'(req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
